result_mem_reader: RTL and testbench

//  Consumer end of the multiplier datapath's result-write interface: captures each
//  32-bit product the datapath writes (we + data_in) into an internal buffer, in order.

---
 rtl/result_mem_reader.sv | 130 +++++++++++++
 tb/tb_result_mem_reader.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/result_mem_reader.sv
// Collects product words from the multiplier datapath into a small buffer and
// streams them to the host over valid/ready once the datapath reports last or the buffer fills.
module result_mem_reader #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 8,
    parameter int ADDR_W = 3
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_start,
    input  logic              i_we,
    input  logic [DATA_W-1:0] i_data_in,
    input  logic              i_last,
    output logic [DATA_W-1:0] o_out_data,
    output logic              o_out_valid,
    input  logic              i_out_ready,
    output logic [ADDR_W:0]   o_count,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_overflow,
    output logic [1:0]        o_state
);

    // Host handshake: a word moves on every rising edge where o_out_valid and
    // i_out_ready are both 1; o_out_valid never looks at i_out_ready, and
    // o_out_data holds steady while o_out_valid is high and i_out_ready is low.
    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_COLLECT = 2'd1,
        S_DRAIN   = 2'd2
    } state_t;

    localparam logic [ADDR_W:0] L_ALMOST = (ADDR_W+1)'(DEPTH - 1);
    localparam logic [ADDR_W:0] L_ONE    = (ADDR_W+1)'(1);

    state_t              r_state;
    state_t              w_next_state;
    logic [DATA_W-1:0]   r_mem [DEPTH];
    logic [ADDR_W-1:0]   r_wr_ptr;
    logic [ADDR_W-1:0]   r_rd_ptr;
    logic [ADDR_W:0]     r_count;
    logic                r_overflow;
    logic                r_done;
    logic                w_store;
    logic                w_xfer;
    logic                w_out_valid;

    // A start in the same cycle as a write aborts the collection, so the word is lost.
    assign w_store = (r_state == S_COLLECT) && i_we && !i_start;
    assign w_xfer  = w_out_valid && i_out_ready;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        if (i_start) begin
            w_next_state = S_COLLECT;
        end else begin
            case (r_state)
                S_IDLE:    w_next_state = S_IDLE;
                S_COLLECT: begin
                    if (i_last || (w_store && r_count == L_ALMOST)) begin
                        w_next_state = S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (r_count == '0 || (r_count == L_ONE && w_xfer)) begin
                        w_next_state = S_IDLE;
                    end
                end
                default:   w_next_state = S_IDLE;
            endcase
        end
    end

    always_comb begin
        o_busy      = (r_state != S_IDLE);
        w_out_valid = (r_state == S_DRAIN) && (r_count != '0);
        o_out_data  = w_out_valid ? r_mem[r_rd_ptr] : '0;
    end

    always_ff @(posedge i_clk) begin
        if (w_store) begin
            r_mem[r_wr_ptr] <= i_data_in;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_done <= (r_state == S_DRAIN) && (w_next_state == S_IDLE);
            if (i_start) begin
                r_wr_ptr   <= '0;
                r_rd_ptr   <= '0;
                r_count    <= '0;
                r_overflow <= 1'b0;
            end else begin
                if (w_store) begin
                    r_wr_ptr <= r_wr_ptr + 1'b1;
                    r_count  <= r_count + 1'b1;
                end
                if (w_xfer) begin
                    r_rd_ptr <= r_rd_ptr + 1'b1;
                    r_count  <= r_count - 1'b1;
                end
                if (r_state == S_DRAIN && i_we) begin
                    r_overflow <= 1'b1;
                end
            end
        end
    end

    assign o_out_valid = w_out_valid;
    assign o_count     = r_count;
    assign o_overflow  = r_overflow;
    assign o_done      = r_done;
    assign o_state     = r_state;

endmodule

// File: tb/tb_result_mem_reader.sv
// Bench for result_mem_reader: directed scenarios plus random traffic, all checked
// every cycle against a queue-based model of the collect/drain behaviour.
module tb_result_mem_reader;

    logic        clk;
    logic        rst;
    logic        start;
    logic        we;
    logic [31:0] data_in;
    logic        last;
    logic [31:0] out_data;
    logic        out_valid;
    logic        out_ready;
    logic [3:0]  count;
    logic        busy;
    logic        done;
    logic        overflow;
    logic [1:0]  state;

    int tests = 0;
    int fails = 0;

    result_mem_reader #(.DATA_W(32), .DEPTH(8), .ADDR_W(3)) dut (
        .i_clk(clk), .i_rst(rst), .i_start(start), .i_we(we), .i_data_in(data_in),
        .i_last(last), .o_out_data(out_data), .o_out_valid(out_valid),
        .i_out_ready(out_ready), .o_count(count), .o_busy(busy), .o_done(done),
        .o_overflow(overflow), .o_state(state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: phase 0 idle, 1 collecting, 2 draining; words kept in a queue.
    int          m_phase = 0;
    logic [31:0] m_buf[$];
    int          m_rd = 0;
    logic        m_ovf = 1'b0;
    logic        m_done = 1'b0;
    logic [31:0] exp_q[$];
    bit          chk_en = 1'b0;

    function automatic logic m_valid();
        return (m_phase == 2) && (m_rd < m_buf.size());
    endfunction

    always @(posedge clk) begin
        logic v;
        v = m_valid();
        m_done = 1'b0;
        if (rst) begin
            m_phase = 0; m_buf.delete(); m_rd = 0; m_ovf = 1'b0; exp_q.delete();
            chk_en = 1'b1;
        end else if (start) begin
            m_phase = 1; m_buf.delete(); m_rd = 0; m_ovf = 1'b0; exp_q.delete();
        end else if (m_phase == 1) begin
            if (we) begin
                m_buf.push_back(data_in);
                exp_q.push_back(data_in);
            end
            if (last || m_buf.size() == 8) m_phase = 2;
        end else if (m_phase == 2) begin
            if (we) m_ovf = 1'b1;
            if (v && out_ready) m_rd++;
            if (m_rd == m_buf.size()) begin
                m_phase = 0;
                m_done = 1'b1;
            end
        end
    end

    // Per-cycle compare plus transfer scoreboard, sampled mid-cycle.
    logic [31:0] got_q[$];
    int          done_cnt = 0;

    always @(negedge clk) begin
        if (chk_en) begin
            chk("count", 32'(count), 32'(m_buf.size() - m_rd));
            chk("busy", 32'(busy), 32'(m_phase != 0));
            chk("out_valid", 32'(out_valid), 32'(m_valid()));
            chk("out_data", out_data, m_valid() ? m_buf[m_rd] : 32'h0);
            chk("done", 32'(done), 32'(m_done));
            chk("overflow", 32'(overflow), 32'(m_ovf));
            if (done) done_cnt++;
            if (out_valid && out_ready && !start && !rst) begin
                got_q.push_back(out_data);
                if (exp_q.size() == 0) chk("sb_underflow", 32'(1), 32'(0));
                else chk("sb_word", out_data, exp_q.pop_front());
            end
        end
    end

    // Driver: inputs change 1 time unit after each rising edge.
    int ready_mode = 0;

    task automatic tick();
        @(posedge clk);
        #1;
        case (ready_mode)
            0: out_ready = 1'b1;
            1: out_ready = ~out_ready;
            2: out_ready = 1'($urandom_range(0, 1));
            default: out_ready = 1'b0;
        endcase
    endtask

    task automatic pulse_start();
        start = 1'b1; tick(); start = 1'b0;
    endtask

    task automatic wr(input logic [31:0] d, input logic l);
        we = 1'b1; data_in = d; last = l;
        tick();
        we = 1'b0; last = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        while (busy && n < budget) begin
            tick();
            n++;
        end
        if (busy) chk("idle_timeout", 32'(busy), 32'(0));
        tick();
    endtask

    task automatic do_reset();
        rst = 1'b1; tick(); tick(); rst = 1'b0;
    endtask

    task automatic chk_got(input string name, input logic [31:0] exp[$]);
        chk({name, "_len"}, 32'(got_q.size()), 32'(exp.size()));
        for (int i = 0; i < exp.size() && i < got_q.size(); i++) chk(name, got_q[i], exp[i]);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; we = 1'b0; data_in = '0; last = 1'b0; out_ready = 1'b1;
        do_reset();
        chk("rst_count", 32'(count), 32'(0));
        chk("rst_busy", 32'(busy), 32'(0));
        chk("rst_valid", 32'(out_valid), 32'(0));

        // T1: three words, host always ready
        ready_mode = 0; got_q.delete(); done_cnt = 0;
        pulse_start();
        wr(32'h0000_0011, 1'b0); wr(32'h0000_2200, 1'b0); wr(32'h0033_0000, 1'b1);
        chk("t1_count3", 32'(count), 32'(3));
        wait_idle(20);
        chk_got("t1_word", '{32'h0000_0011, 32'h0000_2200, 32'h0033_0000});
        chk("t1_done_cnt", 32'(done_cnt), 32'(1));

        // T2: same words, ready toggling
        ready_mode = 1; got_q.delete(); done_cnt = 0;
        pulse_start();
        wr(32'h0000_0011, 1'b0); wr(32'h0000_2200, 1'b0); wr(32'h0033_0000, 1'b1);
        wait_idle(30);
        chk_got("t2_word", '{32'h0000_0011, 32'h0000_2200, 32'h0033_0000});
        chk("t2_done_cnt", 32'(done_cnt), 32'(1));

        // T3: nine writes, buffer fills after eight, ninth is dropped
        ready_mode = 0; got_q.delete(); done_cnt = 0;
        pulse_start();
        for (int i = 1; i <= 9; i++) begin
            wr(32'(i), 1'b0);
            if (i == 8) chk("t3_full", 32'(count), 32'(8));
        end
        wait_idle(30);
        chk("t3_overflow", 32'(overflow), 32'(1));
        chk_got("t3_word", '{32'd1, 32'd2, 32'd3, 32'd4, 32'd5, 32'd6, 32'd7, 32'd8});

        // T4: last with no data
        got_q.delete(); done_cnt = 0;
        pulse_start();
        chk("t4_ovf_cleared", 32'(overflow), 32'(0));
        last = 1'b1; tick(); last = 1'b0;
        chk("t4_drain_busy", 32'(busy), 32'(1));
        chk("t4_drain_valid", 32'(out_valid), 32'(0));
        tick();
        chk("t4_idle_busy", 32'(busy), 32'(0));
        chk("t4_done", 32'(done), 32'(1));
        tick();
        chk("t4_xfers", 32'(got_q.size()), 32'(0));

        // T5: abort a drain after two transfers
        ready_mode = 0; got_q.delete(); done_cnt = 0;
        pulse_start();
        for (int i = 0; i < 5; i++) wr(32'h50 + 32'(i), 1'(i == 4));
        for (int n = 0; n < 20 && got_q.size() < 2; n++) tick();
        chk("t5_two_xfers", 32'(got_q.size()), 32'(2));
        ready_mode = 3; out_ready = 1'b0;
        pulse_start();
        chk("t5_count", 32'(count), 32'(0));
        chk("t5_overflow", 32'(overflow), 32'(0));
        chk("t5_busy", 32'(busy), 32'(1));
        chk("t5_no_done", 32'(done), 32'(0));
        ready_mode = 0;
        wr(32'hA0, 1'b0); wr(32'hA1, 1'b1);
        wait_idle(20);
        chk_got("t5_word", '{32'h50, 32'h51, 32'hA0, 32'hA1});
        chk("t5_done_cnt", 32'(done_cnt), 32'(1));

        // T6: reset mid-collect and mid-drain
        pulse_start();
        for (int i = 0; i < 4; i++) wr(32'hC0 + 32'(i), 1'b0);
        chk("t6_count4", 32'(count), 32'(4));
        rst = 1'b1; tick(); rst = 1'b0;
        chk("t6a_count", 32'(count), 32'(0));
        chk("t6a_busy", 32'(busy), 32'(0));
        chk("t6a_data", out_data, 32'h0);
        wr(32'h77, 1'b1);
        chk("t6_idle_we", 32'(count), 32'(0));
        ready_mode = 3; out_ready = 1'b0;
        pulse_start();
        wr(32'hD0, 1'b0); wr(32'hD1, 1'b0); wr(32'hD2, 1'b1);
        tick();
        chk("t6_drain_cnt", 32'(count), 32'(3));
        rst = 1'b1; tick(); rst = 1'b0;
        chk("t6b_count", 32'(count), 32'(0));
        chk("t6b_valid", 32'(out_valid), 32'(0));
        chk("t6b_busy", 32'(busy), 32'(0));

        // Random traffic
        ready_mode = 2;
        for (int n = 0; n < 600; n++) begin
            rst     = ($urandom_range(0, 149) == 0);
            start   = ($urandom_range(0, 24) == 0);
            we      = ($urandom_range(0, 9) < 6);
            last    = ($urandom_range(0, 11) == 0);
            data_in = $urandom;
            tick();
        end
        rst = 1'b0; start = 1'b0; we = 1'b0; last = 1'b0;
        tick(); tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
